// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the iterative multiply/divide unit.
// Op encodings, FSM state codes, ALU control codes.
package muldiv_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_NEG_A  = 3'd1;
  localparam state_t S_NEG_B  = 3'd2;
  localparam state_t S_ITER   = 3'd3;
  localparam state_t S_FIX_LO = 3'd4;
  localparam state_t S_FIX_HI = 3'd5;
  localparam state_t S_DONE   = 3'd6;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX stage and the mul/div unit.
// master = pipeline side, slave = muldiv_seq.
interface muldiv_seq_if;

  logic                          start;
  logic [1:0]                    op;
  logic [muldiv_pkg::WIDTH-1:0]  src_a;
  logic [muldiv_pkg::WIDTH-1:0]  src_b;
  logic                          flush;
  logic                          busy;
  logic                          done;
  logic [muldiv_pkg::WIDTH-1:0]  hi;
  logic [muldiv_pkg::WIDTH-1:0]  lo;
  logic                          div_by_zero;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/muldiv_seq_alu.sv
// Core 32-bit ALU (AND/OR/ADD/SUB/SLT/NOR).
// Shared by the mul/div sequencer for every add/sub step.
module alu
  import muldiv_pkg::*;
(
  input  logic [3:0]  alu_ctl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_ctl)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      ALU_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) &&
                   (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) &&
                   (diff[31] != a[31]);
      end
      4'b0111: result = {31'b0, diff[31] ^
                         ((a[31] != b[31]) &&
                          (diff[31] != a[31]))};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer driving one shared ALU.
// Fixed 37-cycle latency; results committed to HI/LO on entry to DONE.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op_r;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] hw;
  logic [31:0] lw;
  logic        lo_zero;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        dbz_r;

  logic [3:0]  ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] res;
  logic        zf;
  logic        ovf_unused;

  logic        is_div;
  logic        neg_q;
  logic        neg_h;
  logic [31:0] rsh;
  logic        carry;
  logic        borrow;

  alu u_alu (
    .alu_ctl  (ctl),
    .a        (alu_a),
    .b        (alu_b),
    .result   (res),
    .zero     (zf),
    .overflow (ovf_unused)
  );

  assign is_div = op_r[1];
  assign neg_q  = sign_a ^ sign_b;
  assign neg_h  = is_div ? sign_a : neg_q;
  assign rsh    = {hw[30:0], lw[31]};

  assign carry  = (alu_a[31] & alu_b[31]) |
                  ((alu_a[31] | alu_b[31]) &
                   ~res[31]);
  assign borrow = (~alu_a[31] & alu_b[31]) |
                  ((~alu_a[31] | alu_b[31]) &
                   res[31]);

  // Idle cycles still drive ADD 0+0 so exactly one code is always live.
  always_comb begin
    ctl   = ALU_ADD;
    alu_a = '0;
    alu_b = '0;
    case (state)
      S_NEG_A: begin
        ctl   = ALU_SUB;
        alu_b = a_r;
      end
      S_NEG_B: begin
        ctl   = ALU_SUB;
        alu_b = b_r;
      end
      S_ITER: begin
        if (is_div) begin
          ctl   = ALU_SUB;
          alu_a = rsh;
          alu_b = b_r;
        end else begin
          ctl   = ALU_ADD;
          alu_a = hw;
          alu_b = a_r;
        end
      end
      S_FIX_LO: begin
        ctl   = ALU_SUB;
        alu_b = lw;
      end
      S_FIX_HI: begin
        if (is_div || lo_zero) begin
          ctl   = ALU_SUB;
          alu_b = hw;
        end else begin
          ctl   = ALU_NOR;
          alu_a = hw;
          alu_b = hw;
        end
      end
      default: begin
        ctl   = ALU_ADD;
        alu_a = '0;
        alu_b = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_r    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      hw      <= '0;
      lw      <= '0;
      lo_zero <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      dbz_r   <= 1'b0;
    end else if (state == S_IDLE ||
                 state == S_DONE) begin
      if (bus.start && !bus.flush) begin
        state  <= S_NEG_A;
        op_r   <= bus.op;
        a_r    <= bus.src_a;
        b_r    <= bus.src_b;
        sign_a <= bus.op[0] & bus.src_a[31];
        sign_b <= bus.op[0] & bus.src_b[31];
        hw     <= '0;
      end else begin
        state <= S_IDLE;
      end
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_NEG_A: begin
          if (sign_a) a_r <= res;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          if (sign_b) b_r <= res;
          // divide shifts |a| out of lw; multiply shifts |b| out
          lw    <= is_div ? a_r :
                   (sign_b ? res : b_r);
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (is_div) begin
            if (hw[31] | ~borrow) begin
              hw <= res;
              lw <= {lw[30:0], 1'b1};
            end else begin
              hw <= rsh;
              lw <= {lw[30:0], 1'b0};
            end
          end else if (lw[0]) begin
            {hw, lw} <= {carry, res, lw[31:1]};
          end else begin
            {hw, lw} <= {1'b0, hw, lw[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX_LO;
        end
        S_FIX_LO: begin
          lo_zero <= zf;
          if (neg_q) lw <= res;
          state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          hi_r  <= neg_h ? res : hw;
          lo_r  <= lw;
          dbz_r <= is_div & (b_r == '0);
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE) &&
                           (state != S_DONE);
  assign bus.done        = (state == S_DONE);
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors, expected
// results queued at issue and popped by a done-triggered monitor.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        sbq[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last_hi     = '0;
  logic [31:0] last_lo     = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious done: hi=%h lo=%h",
                 bus.hi, bus.lo);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("div_by_zero", 32'(bus.div_by_zero),
            32'(e.dbz));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  task automatic issue(input logic [1:0]  o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] eh,
                       input logic [31:0] el,
                       input logic        ed,
                       input bit          push);
    exp_t e;
    e.hi  = eh;
    e.lo  = el;
    e.dbz = ed;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    if (push) sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm,
                           input int n0);
    int n;
    n = n0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd37);
  endtask

  task automatic op_run(input string nm,
                        input logic [1:0]  o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input logic        ed);
    issue(o, a, b, eh, el, ed, 1'b1);
    wait_done(nm, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.src_a = '0;
    bus.src_b = '0;

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;

    // cycle-exact busy/done profile on the first op
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
    for (int cyc = 1; cyc <= 37; cyc++) begin
      chk($sformatf("busy c%0d", cyc), 32'(bus.busy),
          32'(cyc <= 36));
      chk($sformatf("done c%0d", cyc), 32'(bus.done),
          32'(cyc == 37));
      if (cyc < 37) @(negedge clk);
    end

    op_run("mult neg", OP_MULT, 32'hFFFFFFFD,
           32'h00000007, 32'hFFFFFFFF,
           32'hFFFFFFEB, 1'b0);
    op_run("mult lo0", OP_MULT, 32'h00010000,
           32'hFFFF0000, 32'hFFFFFFFF,
           32'h00000000, 1'b0);
    op_run("mult min", OP_MULT, 32'h80000000,
           32'h80000000, 32'h40000000,
           32'h00000000, 1'b0);
    op_run("div neg", OP_DIV, 32'hFFFFFFF9,
           32'h00000002, 32'hFFFFFFFF,
           32'hFFFFFFFD, 1'b0);
    op_run("divu", OP_DIVU, 32'h00000064,
           32'h00000007, 32'h00000002,
           32'h0000000E, 1'b0);
    op_run("divu by 0", OP_DIVU, 32'h00000005,
           32'h00000000, 32'h00000005,
           32'hFFFFFFFF, 1'b1);
    op_run("div wrap", OP_DIV, 32'h80000000,
           32'hFFFFFFFF, 32'h00000000,
           32'h80000000, 1'b0);
    op_run("div neg by 0", OP_DIV, 32'hFFFFFFF6,
           32'h00000000, 32'hFFFFFFF6,
           32'h00000001, 1'b1);

    // flush in cycle 10: no commit, no done
    issue(OP_MULTU, 32'h3, 32'h5, '0, '0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy", 32'(bus.busy), 32'd0);
    chk("flush done", 32'(bus.done), 32'd0);
    chk("flush hi", bus.hi, last_hi);
    chk("flush lo", bus.lo, last_lo);
    repeat (40) @(negedge clk);
    chk("flush idle", 32'(bus.busy), 32'd0);

    // start while busy is ignored
    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14,
          1'b0, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd2;
    bus.src_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy start", 6);

    // start in the DONE cycle is accepted
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.src_a = 32'h00000007;
    bus.src_b = 32'hFFFFFFFD;
    sbq.push_back('{32'hFFFFFFFF, 32'hFFFFFFEB,
                    1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("done start", 1);

    op_run("divu by 0 b", OP_DIVU, 32'h00000005,
           32'h00000000, 32'h00000005,
           32'hFFFFFFFF, 1'b1);

    // async reset mid-ITER, between edges
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, '0, '0,
          1'b0, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst hi", bus.hi, 32'd0);
    chk("rst lo", bus.lo, 32'd0);
    chk("rst dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op_run("post rst", OP_MULTU, 32'h00001234,
           32'h00010000, 32'h00000000,
           32'h12340000, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide controller for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU.
- It sequences one 32-bit alu instance through sign-fix, 32 add/sub steps and result-fix. Results go into committed HI/LO registers.
- busy stalls the EX stage; done tells the pipeline that HI/LO are fresh.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported because alu is fixed-width. The iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src_a  input  32  multiplicand or dividend.
- src_b  input  32  multiplier or divisor.
- flush  input  1  abort the in-flight operation.
- busy  output  1  high in states NEG_A through FIX_HI.
- done  output  1  one-cycle pulse in state DONE.
- hi  output  32  committed HI: product[63:32] or remainder.
- lo  output  32  committed LO: product[31:0] or quotient.
- div_by_zero  output  1  registered flag: the last DIV/DIVU had src_b==0.

Behaviour:
- Reset is asynchronous and immediate. State becomes IDLE; busy, done, hi, lo and div_by_zero become 0; all working registers are cleared.
- States: IDLE -> NEG_A -> NEG_B -> ITER (x32) -> FIX_LO -> FIX_HI -> DONE -> IDLE.
- start accept: when start=1 in IDLE or DONE at edge E0, op, src_a and src_b are latched and the next state is NEG_A.
- start is ignored while busy.
- flush has priority over start. flush=1 in any busy state returns to IDLE at the next edge; hi, lo and div_by_zero keep their previous values and done is never pulsed.
- Fixed latency: NEG_A is cycle 1 after E0 and DONE is cycle 37. Every state always occupies its cycle, even when no negation is needed.
- ALU control codes: ADD 0010, SUB 0110, NOR 1100. Each cycle drives exactly one code.
- NEG_A / NEG_B:
  - For signed ops with a negative operand, the operand becomes its magnitude via SUB(0, x). 0x80000000 stays 0x80000000, read as unsigned 2^31.
  - neg_res = sign_a XOR sign_b for multiply, and sign_a for the remainder.
  - For unsigned ops these states are a no-op.
- ITER, multiply (shift-add):
  - If lo[0]=1: {c,s} = hi + mcand using ADD. Otherwise {c,s} = {0,hi}.
  - Then {hi,lo} <= {c, s, lo[31:1]}.
  - Unsigned carry c = (a31&b31) | ((a31|b31)&~r31).
- ITER, divide (restoring):
  - Shift {msb, rem, q} left, bringing in the next dividend bit.
  - diff = rem - divisor using SUB. Borrow = (~a31&b31) | ((~a31|b31)&r31).
  - If msb=1 or there is no borrow: rem <= diff and the quotient bit is 1. Otherwise the quotient bit is 0.
- FIX_LO: if negation is needed, lo <= SUB(0, lo).
  - Multiply: negate if neg_res. Divide: negate the quotient if sign_a XOR sign_b.
- FIX_HI:
  - Divide: hi <= SUB(0, hi) if sign_a.
  - Multiply with neg_res: hi <= SUB(0, hi) if the pre-fix lo was 0; otherwise hi <= NOR(hi, hi). This forms the 64-bit two's complement.
- DONE:
  - hi, lo and div_by_zero are loaded at the transition into DONE; done=1 and busy=0.
  - Outputs hold until the next commit.
- Divide by zero is not a special case; the result is whatever the algorithm produces.
  - DIVU gives lo=FFFFFFFF, hi=src_a.
  - DIV gives hi=src_a, and lo=00000001 if src_a<0, else FFFFFFFF.
  - div_by_zero=1 for either divide; it is 0 for multiplies.
- DIV 0x80000000 / 0xFFFFFFFF wraps: lo=80000000, hi=00000000, no flag.

Decomposition:
- muldiv_pkg holds: op encodings; the state enum; the ALU_ctl constants (ALU_ADD, ALU_SUB, ALU_NOR); WIDTH.
- Sub-module: one instance of the existing alu, with zero and overflow unused.
- Carry/borrow derivation is inline logic.

Test Plan:
1. MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001. busy high for cycles 1-36, done only in cycle 37.
2. MULT FFFFFFFD x 00000007 -> hi=FFFFFFFF, lo=FFFFFFEB. MULT 00010000 x FFFF0000 -> hi=FFFFFFFF, lo=00000000 (exercises the lo==0 borrow path).
3. DIV FFFFFFF9 / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 00000064 / 00000007 -> lo=0000000E, hi=00000002.
4. DIVU 5 / 0 -> lo=FFFFFFFF, hi=5, div_by_zero=1. DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0, div_by_zero=0.
5. flush in cycle 10 of a MULTU -> busy=0 next cycle, no done, hi/lo unchanged. start in cycle 5 of a busy op is ignored. start in the DONE cycle is accepted, with its done in cycle 37 after it.
6. rst asserted mid-ITER, between clock edges -> busy, done, hi, lo, div_by_zero read 0 immediately. Next start after rst release completes normally.
